// File: rtl/tag_allocator_if.sv
// rtl/tag_allocator_if.sv - dispatch/retire handshake bundle for the tag allocator
interface tag_allocator_if #(
  parameter int NUM_TAGS  = 16,
  parameter int TAG_WIDTH = 4
);
  localparam int CW = $clog2(NUM_TAGS + 1);

  logic                 alloc_req;
  logic                 alloc_gnt;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic                 free_valid;
  logic [TAG_WIDTH-1:0] free_tag;
  logic                 flush;
  logic [CW-1:0]        free_count;
  logic                 empty;
  logic                 error;

  // Dispatch/retire side: requests, releases and flush; observes allocator state.
  modport master (
    output alloc_req, free_valid, free_tag, flush,
    input  alloc_gnt, alloc_tag, free_count, empty, error
  );

  // Allocator side.
  modport slave (
    input  alloc_req, free_valid, free_tag, flush,
    output alloc_gnt, alloc_tag, free_count, empty, error
  );
endinterface

// File: rtl/tag_allocator.sv
// rtl/tag_allocator.sv - circular free-list tag allocator with in-use bitmap release checking
module tag_allocator #(
  parameter int NUM_TAGS  = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  tag_allocator_if.slave  bus
);
  localparam int PW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int CW = $clog2(NUM_TAGS + 1);

  logic [TAG_WIDTH-1:0] list [NUM_TAGS];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;
  logic [NUM_TAGS-1:0]  in_use;
  logic                 error_q;

  logic                 grant;
  logic                 tag_in_range;
  logic                 rel_ok;
  logic                 rel_bad;
  logic [PW-1:0]        head_nxt;
  logic [PW-1:0]        tail_nxt;

  // Grant/release qualification and explicit (non power-of-two) pointer wrap.
  always_comb begin
    grant        = bus.alloc_req & (count != '0) & ~bus.flush;
    tag_in_range = int'(bus.free_tag) < NUM_TAGS;
    rel_ok       = bus.free_valid & ~bus.flush & tag_in_range & in_use[bus.free_tag];
    rel_bad      = bus.free_valid & ~bus.flush & ~(tag_in_range & in_use[bus.free_tag]);
    head_nxt     = (head == PW'(NUM_TAGS - 1)) ? '0 : head + PW'(1);
    tail_nxt     = (tail == PW'(NUM_TAGS - 1)) ? '0 : tail + PW'(1);
  end

  // Free list, pointers, count and in-use bitmap; flush re-runs the reset image.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TAGS; i++) list[i] <= TAG_WIDTH'(i);
      head   <= '0;
      tail   <= '0;
      count  <= CW'(NUM_TAGS);
      in_use <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_TAGS; i++) list[i] <= TAG_WIDTH'(i);
      head   <= '0;
      tail   <= '0;
      count  <= CW'(NUM_TAGS);
      in_use <= '0;
    end else begin
      if (grant) begin
        head                 <= head_nxt;
        in_use[list[head]]   <= 1'b1;
      end
      // Placed after the grant so a same-index clear overrides the set.
      if (rel_ok) begin
        list[tail]           <= bus.free_tag;
        tail                 <= tail_nxt;
        in_use[bus.free_tag] <= 1'b0;
      end
      case ({grant, rel_ok})
        2'b10:   count <= count - CW'(1);
        2'b01:   count <= count + CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky illegal-release flag; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else if (rel_bad) begin
      error_q <= 1'b1;
    end
  end

  assign bus.alloc_gnt  = grant;
  assign bus.alloc_tag  = list[head];
  assign bus.free_count = count;
  assign bus.empty      = (count == '0);
  assign bus.error      = error_q;
endmodule

// File: tb/tb_tag_allocator.sv
// tb/tb_tag_allocator.sv - scoreboard bench for tag_allocator
module tb_tag_allocator;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  tag_allocator_if #(.NUM_TAGS(16), .TAG_WIDTH(4)) bus ();

  tag_allocator #(.NUM_TAGS(16), .TAG_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int m_list[$];
  bit m_in_use[16];
  bit m_err;
  int exp_q[$];
  int outstanding[$];
  bit last_g;
  int last_gtag;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_init();
    m_list.delete();
    for (int i = 0; i < 16; i++) begin
      m_list.push_back(i);
      m_in_use[i] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    bus.alloc_req  = 1'b0;
    bus.free_valid = 1'b0;
    bus.free_tag   = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    bus.alloc_req = 1'b1;
    #1;
    check("rst_gnt_follows_req", bus.alloc_gnt, 1);
    bus.alloc_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_init();
    m_err = 1'b0;
    exp_q.delete();
    outstanding.delete();
  endtask

  // One cycle: drive, predict, compare before the edge, advance the model.
  task automatic step(input bit req, input bit fv, input int ft, input bit fl);
    bit g;
    bit legal;
    bus.alloc_req  = req;
    bus.free_valid = fv;
    bus.free_tag   = 4'(ft);
    bus.flush      = fl;
    g = req && (m_list.size() != 0) && !fl;
    if (g) exp_q.push_back(m_list[0]);
    #1;
    check("alloc_gnt", bus.alloc_gnt, g);
    check("free_count", bus.free_count, m_list.size());
    check("empty", bus.empty, m_list.size() == 0);
    check("error", bus.error, m_err);
    if (bus.alloc_gnt) begin
      if (exp_q.size() == 0) check("gnt_unexpected", bus.alloc_gnt, 0);
      else check("alloc_tag", bus.alloc_tag, exp_q.pop_front());
    end else if (g) begin
      void'(exp_q.pop_back());
    end
    last_g    = g;
    last_gtag = g ? m_list[0] : -1;
    if (fl) begin
      model_init();
    end else begin
      legal = fv && (ft >= 0) && (ft < 16) && m_in_use[ft];
      if (fv && !legal) m_err = 1'b1;
      if (g) begin
        m_in_use[m_list[0]] = 1'b1;
        void'(m_list.pop_front());
      end
      if (legal) begin
        m_list.push_back(ft);
        m_in_use[ft] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);

    // Reset state and full drain in order 0..15
    do_reset();
    check("rst_count", bus.free_count, 16);
    check("rst_tag", bus.alloc_tag, 0);
    check("rst_empty", bus.empty, 0);
    check("rst_error", bus.error, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    check("drain_count", bus.free_count, 0);
    check("drain_empty", bus.empty, 1);
    step(1, 0, 0, 0);

    // Release 7 then 3, reused in that order
    step(0, 1, 7, 0);
    check("rel7_count", bus.free_count, 1);
    check("rel7_tag", bus.alloc_tag, 7);
    step(0, 1, 3, 0);
    check("rel3_count", bus.free_count, 2);
    step(1, 0, 0, 0);
    check("gnt7_count", bus.free_count, 1);
    step(1, 0, 0, 0);
    check("gnt3_count", bus.free_count, 0);

    // Empty list with a release in the same cycle: no bypass
    step(1, 1, 9, 0);
    check("nobypass_tag", bus.alloc_tag, 9);
    step(1, 0, 0, 0);

    // Double free is flagged, leaves count/order alone, survives flush
    do_reset();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("dbl_error", bus.error, 1);
    check("dbl_count", bus.free_count, 16);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("err_after_flush", bus.error, 1);
    step(0, 0, 0, 0);

    // One tag free: grant and release together keep count at 1
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0);
    step(1, 1, 5, 0);
    check("one_free_count", bus.free_count, 1);
    check("one_free_tag", bus.alloc_tag, 5);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Wrap-around: 40 cycles of allocate-and-release with 4 held
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      outstanding.push_back(last_gtag);
    end
    for (int i = 0; i < 40; i++) begin
      int ft;
      ft = outstanding.pop_front();
      step(1, 1, ft, 0);
      if (last_g) outstanding.push_back(last_gtag);
    end
    check("wrap_count", bus.free_count, 12);
    check("wrap_error", bus.error, 0);

    // Flush with 5 outstanding and a same-cycle request
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    check("flush_count", bus.free_count, 16);
    check("flush_tag", bus.alloc_tag, 0);
    step(0, 1, 1, 0);
    check("flush_inuse_clear", bus.error, 1);
    step(0, 0, 0, 0);

    // Asynchronous reset mid-cycle
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    bus.alloc_req = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_count", bus.free_count, 16);
    check("async_tag", bus.alloc_tag, 0);
    check("async_empty", bus.empty, 0);
    check("async_error", bus.error, 0);
    check("async_gnt", bus.alloc_gnt, 1);
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    model_init();
    m_err = 1'b0;
    exp_q.delete();
    step(1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tag_allocator.md
# tag_allocator

Free-list allocator that hands out reservation-station / ROB tags at dispatch and reclaims them when the tagged result retires. It is the producer side of the in-order tag queue: each granted tag is what dispatch pushes downstream, and each retired tag comes back here for reuse. The free list is a circular buffer of tag values. A per-tag in-use bitmap rejects illegal or double releases.

## Interface
- NUM_TAGS, 16, number of distinct tags managed (2..2**TAG_WIDTH)
- TAG_WIDTH, 4, width of a tag value

- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- alloc_req  in  1  dispatch requests one tag this cycle
- alloc_gnt  out  1  request granted this cycle (combinational)
- alloc_tag  out  TAG_WIDTH  tag at head of free list; valid when free_count != 0
- free_valid  in  1  release one tag this cycle
- free_tag  in  TAG_WIDTH  tag being released
- flush  in  1  synchronous: return every tag to the free list
- free_count  out  $clog2(NUM_TAGS+1)  tags currently available
- empty  out  1  free_count == 0
- error  out  1  sticky: an illegal release was seen

## Operation
- Storage:
  - list[NUM_TAGS] of TAG_WIDTH.
  - head and tail pointers, each in 0..NUM_TAGS-1. On increment they wrap explicitly to 0 after NUM_TAGS-1; power-of-two wrap is not assumed.
  - count, 0..NUM_TAGS.
  - in_use[NUM_TAGS] bitmap.
- Reset (reset_n=0, asynchronous):
  - list[i]=i; head=0, tail=0, count=NUM_TAGS.
  - in_use all 0; error=0.
  - Outputs: alloc_tag=0, free_count=NUM_TAGS, empty=0, alloc_gnt=alloc_req.
- Grant: alloc_gnt = alloc_req & (count != 0) & ~flush.
  - On a grant: head advances and in_use[list[head]] is set.
- Release accepted when all of the following hold: free_valid=1, flush=0, free_tag < NUM_TAGS, in_use[free_tag]=1.
  - Accepted release: list[tail] <= free_tag, tail advances, in_use[free_tag] is cleared.
- Illegal release: free_tag >= NUM_TAGS, or in_use[free_tag]=0 (double free or never allocated).
  - No state change; error <= 1.
  - error stays set until reset; flush does not clear it.
- count update:
  - +1 on an accepted release, -1 on a grant.
  - Both in the same cycle: count unchanged, head and tail both advance.
- Simultaneous grant and accepted release of the same tag value is legal; both updates apply.
  - Set and clear of in_use for the same index in one cycle: the release's clear wins.
- Empty with free_valid in the same cycle: no bypass. alloc_gnt=0; the freed tag is usable from the next cycle.
- Full (count=NUM_TAGS): every tag has in_use=0, so any release is illegal and flagged.
- flush=1: next edge re-executes the reset initialisation except error. Same-cycle alloc/free are ignored.
- alloc_tag always shows list[head], even when no request is pending. Allocation order is FIFO over release order.

## Timing
- Grant latency 0: alloc_gnt and alloc_tag are valid in the same cycle as alloc_req. The caller samples alloc_tag when alloc_gnt=1.
- State updates take effect at the next rising edge. free_count, empty and the new alloc_tag are visible the following cycle.
- A released tag reaches alloc_tag only after every tag ahead of it in the list has been granted. Minimum release-to-reuse is 1 cycle, when the list was empty.
- Asynchronous assert of reset_n mid-operation: all state returns to reset values immediately, with no dependence on clk. Deassertion is synchronised externally.

## Test plan
- Reset, then alloc_req=1 for 16 cycles:
  - Tags granted are 0,1,…,15, one per cycle.
  - After the last grant: free_count=0, empty=1.
  - A 17th request gives alloc_gnt=0.
- After draining, release 7 then 3:
  - Next grants are 7 then 3.
  - free_count goes 0→1→2→1→0.
- After allocating only tag 0, release 0 again in a later cycle:
  - error=1; free_count unchanged; tail unchanged.
  - error stays 1 through a subsequent flush.
- With 1 tag free, alloc_req=1 and release of an allocated tag in the same cycle:
  - Grant succeeds; free_count stays 1; the released tag appears at alloc_tag later, in FIFO order.
- Wrap-around: 40 cycles of allocate-and-release in the same cycle:
  - head and tail wrap 15→0 without corruption.
  - The sequence of granted tags matches a software free-list model.
  - free_count is constant.
- With 5 tags outstanding, pulse flush together with alloc_req=1:
  - alloc_gnt=0 that cycle.
  - Next cycle: free_count=16, alloc_tag=0, in_use all clear.
  - Assert reset_n=0 mid-cycle: outputs return to reset values before the next edge.
